split_poly_even_odd: RTL and testbench
======================================

Name: split_poly_even_odd

Overview:
- Bit-serial splitter for the Niederreiter/Patterson datapath.
- Takes a GF(2) polynomial P of DAT_W bits and produces two halves, P0 and P1, such that P(x) = P0(x)^2 + x*P1(x)^2.
- The halves are the even-power and odd-power coefficient streams, used by the polynomial square-root step.
- Consumes 2 input bits per clock; results are held until the next start or reset.

Parameters:
- DAT_W, 144: input/output vector width; must be even. Operation latency is DAT_W/2 cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst_b  input  1  reset; asynchronous, active-low.
- start  input  1  one-cycle request; poly_in is sampled in the same cycle.
- poly_in  input  [0:DAT_W-1]  polynomial. Bit i is the coefficient of x^(DAT_W-1-i), so bit 0 is the highest degree.
- first_fragment_out  output  [0:DAT_W-1]  P0 (even-power coefficients), right-aligned, upper DAT_W/2 bits zero.
- second_fragment_out  output  [0:DAT_W-1]  P1 (odd-power coefficients), right-aligned, upper DAT_W/2 bits zero.

Behaviour:
- Final mapping, for k = 0..DAT_W/2-1:
  - first_fragment_out[DAT_W/2+k] = poly_in[2k+1]
  - second_fragment_out[DAT_W/2+k] = poly_in[2k]
  - bits [0:DAT_W/2-1] of both outputs = 0.
- State machine states: IDLE, BUSY, DONE.
- Reset (rst_b=0, asynchronous): state=IDLE, shift register=0, counter=0, both outputs=0.
- IDLE or DONE with start=1:
  - load poly_in into the shift register;
  - clear both outputs to 0;
  - counter=0; go to BUSY.
- BUSY, each clock:
  - first output shifts left by 1 and takes shift register bit 1 in at the LSB;
  - second output shifts left by 1 and takes bit 0 in at the LSB;
  - shift register shifts left by 2 with zero fill;
  - counter increments.
- BUSY exits to DONE on the edge where counter reaches DAT_W/2 (72 shift edges after the load edge).
- Outputs are final and stable from that edge onward. Intermediate values are visible during BUSY and are not valid.
- start during BUSY: ignored; the running operation is unaffected.
- start in DONE: restarts immediately, so outputs return to 0 at the load edge.
- rst_b low mid-operation: aborts; all state clears; IDLE.
- Outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: SPLIT_DONE_EN.
- When defined:
  - extra output port done (1 bit);
  - done is high for exactly one cycle, on the cycle after the BUSY to DONE transition edge;
  - reset value 0.
- When not defined: the port is absent. Consumers wait a fixed DAT_W/2+1 cycles after the start cycle.

Decomposition:
- Shared package holds:
  - DAT_W default (144);
  - derived HALF_W = DAT_W/2;
  - counter width = clog2(HALF_W+1);
  - state encoding localparams IDLE/BUSY/DONE.
- One natural sub-module, split_shift_unit: the 2-bit-per-cycle shift register plus the two output accumulators, with load/shift enables.
- The top level holds the FSM and the counter.

Test Plan:
- All-ones poly_in, start pulse:
  - after 72 edges, both outputs = 72 zeros followed by 72 ones;
  - outputs stay unchanged for 100 further cycles.
- poly_in with only bit 0 set (x^143): after 72 edges, second_fragment_out has only bit 72 set and first_fragment_out = 0.
- poly_in = alternating 1,0 from bit 0 (0xAAAA…A): second_fragment_out low half all ones, first_fragment_out = 0. Repeat with 0x5555…5: results swap.
- Random vector (e.g. 0x9FB69D18BCC383871C4C002A894A0D4B6CEE4695):
  - check every bit against the mapping above;
  - then reset, restart with the same vector with its low 17 bits zeroed, and check again.
- start re-asserted at cycle 30 of BUSY with a different poly_in: ignored; the result equals the first vector's split at cycle 72.
- rst_b pulsed low at cycle 40 of BUSY: outputs become 0 immediately (asynchronously). A following start gives a correct full result 72 edges later.

Source files
------------

// File: rtl/split_poly_even_odd_pkg.sv
// Shared constants for the even/odd polynomial splitter.
// Holds the default width, derived sizes and FSM state encodings.
package split_poly_even_odd_pkg;

    localparam int DAT_W_DEF = 144;
    localparam int HALF_W    = DAT_W_DEF / 2;
    localparam int CNT_W     = $clog2(HALF_W + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/split_poly_even_odd_shift_unit.sv
// Two-bit-per-cycle shift register feeding the even/odd accumulators.
// Bit 0 of each vector is its most significant end.
module split_shift_unit
    import split_poly_even_odd_pkg::*;
#(
    parameter int DAT_W = DAT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             load,
    input  logic             shift,
    input  logic [0:DAT_W-1] data,
    output logic [0:DAT_W-1] first,
    output logic [0:DAT_W-1] second
);

    logic [0:DAT_W-1] sreg;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sreg   <= '0;
            first  <= '0;
            second <= '0;
        end else if (load) begin
            sreg   <= data;
            first  <= '0;
            second <= '0;
        end else if (shift) begin
            // Index 0 is the top: shifting left moves bits toward index 0.
            sreg   <= {sreg[2:DAT_W-1], 2'b00};
            first  <= {first[1:DAT_W-1], sreg[1]};
            second <= {second[1:DAT_W-1], sreg[0]};
        end
    end

endmodule

// File: rtl/split_poly_even_odd.sv
// Splits P into P0/P1 with P = P0^2 + x*P1^2, two bits per clock.
// Define SPLIT_DONE_EN to add a one-cycle done pulse output.
module split_poly_even_odd
    import split_poly_even_odd_pkg::*;
#(
    parameter int DAT_W = DAT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic [0:DAT_W-1] poly_in,
`ifdef SPLIT_DONE_EN
    output logic             done,
`endif
    output logic [0:DAT_W-1] first_fragment_out,
    output logic [0:DAT_W-1] second_fragment_out
);

    localparam int HW = DAT_W / 2;
    localparam int CW = $clog2(HW + 1);
    localparam logic [CW-1:0] LAST = CW'(HW - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          load;
    logic          shift;

    assign load  = start && (state != BUSY);
    assign shift = (state == BUSY);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= BUSY;
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPLIT_DONE_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) done <= 1'b0;
        else        done <= shift && (cnt == LAST);
    end
`endif

    split_shift_unit #(.DAT_W(DAT_W)) u_shift (
        .clk    (clk),
        .rst_b  (rst_b),
        .load   (load),
        .shift  (shift),
        .data   (poly_in),
        .first  (first_fragment_out),
        .second (second_fragment_out)
    );

endmodule

// File: tb/tb_split_poly_even_odd.sv
// Randomized self-checking bench for split_poly_even_odd.
// Honors SPLIT_DONE_EN when defined for the whole build.
module tb_split_poly_even_odd;

    localparam int W = 144;
    localparam int H = W / 2;

    logic         clk = 1'b0;
    logic         rst_b = 1'b0;
    logic         start = 1'b0;
    logic [0:W-1] poly_in = '0;
    logic [0:W-1] f_out;
    logic [0:W-1] s_out;
`ifdef SPLIT_DONE_EN
    logic         done;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    split_poly_even_odd #(.DAT_W(W)) dut (
        .clk                 (clk),
        .rst_b               (rst_b),
        .start               (start),
        .poly_in             (poly_in),
`ifdef SPLIT_DONE_EN
        .done                (done),
`endif
        .first_fragment_out  (f_out),
        .second_fragment_out (s_out)
    );

    // Reference: even-power coefficients go to P0, odd-power to P1.
    function automatic logic [0:W-1] ref_p0(input logic [0:W-1] p);
        logic [0:W-1] r = '0;
        for (int k = 0; k < H; k++) r[H + k] = p[2 * k + 1];
        return r;
    endfunction

    function automatic logic [0:W-1] ref_p1(input logic [0:W-1] p);
        logic [0:W-1] r = '0;
        for (int k = 0; k < H; k++) r[H + k] = p[2 * k];
        return r;
    endfunction

    function automatic logic [0:W-1] rand_vec();
        logic [0:W-1] r;
        for (int i = 0; i < W; i++) r[i] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    // Returns at the negedge right after the load edge.
    task automatic kick(input logic [0:W-1] v);
        @(negedge clk);
        start   = 1'b1;
        poly_in = v;
        @(negedge clk);
        start   = 1'b0;
        poly_in = rand_vec();
    endtask

    task automatic check_result(input string name, input logic [0:W-1] v);
        logic [0:W-1] e0;
        logic [0:W-1] e1;
        e0 = ref_p0(v);
        e1 = ref_p1(v);
        checks++;
        if (f_out !== e0) begin
            errors++;
            $display("FAIL %s first: got %h want %h", name, f_out, e0);
        end
        checks++;
        if (s_out !== e1) begin
            errors++;
            $display("FAIL %s second: got %h want %h", name, s_out, e1);
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        #12;
        checks++;
        if (f_out !== '0 || s_out !== '0) begin
            errors++;
            $display("FAIL reset outputs: got %h %h want 0", f_out, s_out);
        end
`ifdef SPLIT_DONE_EN
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset done: got %b want 0", done);
        end
`endif
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    task automatic test_all_ones();
        logic [0:W-1] v = '1;
        kick(v);
        repeat (H - 1) @(negedge clk);
`ifdef SPLIT_DONE_EN
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done early: got %b want 0", done);
        end
`endif
        @(negedge clk);
        check_result("all_ones", v);
`ifdef SPLIT_DONE_EN
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done pulse: got %b want 1", done);
        end
`endif
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
`ifdef SPLIT_DONE_EN
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL done width c=%0d: got %b want 0", c, done);
            end
`endif
            check_result("all_ones_hold", v);
        end
    endtask

    task automatic test_single_bit();
        logic [0:W-1] v = '0;
        v[0] = 1'b1;
        kick(v);
        repeat (H) @(negedge clk);
        checks++;
        if (s_out[H] !== 1'b1 || f_out !== '0) begin
            errors++;
            $display("FAIL single_bit: got %h %h", f_out, s_out);
        end
        check_result("single_bit", v);
    endtask

    task automatic test_alternating();
        logic [0:W-1] v;
        for (int i = 0; i < W; i++) v[i] = (i % 2 == 0);
        kick(v);
        repeat (H) @(negedge clk);
        check_result("alt_aa", v);
        v = ~v;
        kick(v);
        repeat (H) @(negedge clk);
        check_result("alt_55", v);
    endtask

    task automatic test_given_vector();
        logic [159:0] big = 160'h9FB69D18BCC383871C4C002A894A0D4B6CEE4695;
        logic [0:W-1] v;
        v = big[W-1:0];
        kick(v);
        repeat (H) @(negedge clk);
        check_result("vec", v);
        do_reset();
        for (int i = W - 17; i < W; i++) v[i] = 1'b0;
        kick(v);
        repeat (H) @(negedge clk);
        check_result("vec_low17", v);
    endtask

    task automatic test_random();
        logic [0:W-1] v;
        for (int n = 0; n < 8; n++) begin
            v = rand_vec();
            kick(v);
            repeat (H) @(negedge clk);
            check_result("random", v);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic test_start_in_busy();
        logic [0:W-1] v = rand_vec();
        logic [0:W-1] other = ~v;
        kick(v);
        for (int c = 1; c <= H; c++) begin
            @(negedge clk);
            if (c == 30) begin
                start   = 1'b1;
                poly_in = other;
            end else if (c == 31) begin
                start = 1'b0;
            end
        end
        check_result("start_in_busy", v);
    endtask

    task automatic test_reset_mid_op();
        logic [0:W-1] v = rand_vec();
        kick(v);
        repeat (40) @(negedge clk);
        #2;
        rst_b = 1'b0;
        #1;
        checks++;
        if (f_out !== '0 || s_out !== '0) begin
            errors++;
            $display("FAIL async_reset: got %h %h want 0", f_out, s_out);
        end
        @(negedge clk);
        rst_b = 1'b1;
        v = rand_vec();
        kick(v);
        repeat (H) @(negedge clk);
        check_result("after_reset", v);
    endtask

    task automatic test_back_to_back();
        logic [0:W-1] v = rand_vec();
        kick(v);
        checks++;
        if (f_out !== '0 || s_out !== '0) begin
            errors++;
            $display("FAIL restart_clear: got %h %h want 0", f_out, s_out);
        end
        repeat (H) @(negedge clk);
        check_result("back_to_back", v);
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_single_bit();
        test_alternating();
        test_given_vector();
        test_random();
        test_start_in_busy();
        test_reset_mid_op();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
